// File: rtl/calendar_pkg.sv
// Calendar constants and helpers shared by the date counter and its month-length lookup.
//   MONTH_LEN   : non-leap month lengths, Jan..Dec
//   isLeapYear  : Gregorian leap rule on a zero-extended year
//   monthLength : days in a month, 0 for a month outside 1..12
package calendar_pkg;

    localparam int unsigned DAY_W   = 6;
    localparam int unsigned MONTH_W = 4;

    localparam logic [DAY_W-1:0] MONTH_LEN [12] = '{
        6'd31, 6'd28, 6'd31, 6'd30, 6'd31, 6'd30,
        6'd31, 6'd31, 6'd30, 6'd31, 6'd30, 6'd31
    };

    // Year 0 satisfies y%400==0, so it counts as leap.
    function automatic logic isLeapYear(input logic [31:0] y);
        return ((y % 32'd4) == 32'd0) &&
               (((y % 32'd100) != 32'd0) || ((y % 32'd400) == 32'd0));
    endfunction

    function automatic logic [DAY_W-1:0] monthLength(input logic [MONTH_W-1:0] m,
                                                     input logic leap);
        logic [MONTH_W-1:0] idx;
        logic [DAY_W-1:0]   len;
        idx = m - MONTH_W'(1);
        if ((m == '0) || (m > MONTH_W'(12))) begin
            len = '0;
        end else if ((m == MONTH_W'(2)) && leap) begin
            len = DAY_W'(29);
        end else begin
            len = MONTH_LEN[idx];
        end
        return len;
    endfunction

endpackage

// File: rtl/month_length_lut.sv
// Combinational (month, year) -> (month length, leap flag).
//   month_i  : month 1..12 (anything else yields length_o = 0)
//   year_i   : full-width year
//   length_o : days in that month of that year
//   leap_o   : year_i is a leap year
module month_length_lut
    import calendar_pkg::*;
#(
    parameter int unsigned YEAR_W = 12
) (
    input  logic [MONTH_W-1:0] month_i,
    input  logic [YEAR_W-1:0]  year_i,
    output logic [DAY_W-1:0]   length_o,
    output logic               leap_o
);

    always_comb begin
        leap_o   = isLeapYear(32'(year_i));
        length_o = monthLength(month_i, leap_o);
    end

endmodule

// File: rtl/date_counter.sv
// Calendar date register advanced one day per advance strobe, with validated parallel load.
//   clk, reset                   : clock, synchronous active-high reset
//   advance                      : move the date forward one day
//   load, loadDay/Month/Year     : replace the date if legal (load beats advance)
//   dayOfMonth, month, year      : registered current date
//   isLeap                       : current year is leap (combinational from year)
//   newYear, yearWrap, loadErr   : registered one-cycle event pulses
module date_counter
    import calendar_pkg::*;
#(
    parameter int unsigned YEAR_W      = 12,
    parameter int unsigned RESET_YEAR  = 2000,
    parameter int unsigned RESET_MONTH = 1,
    parameter int unsigned RESET_DAY   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               advance,
    input  logic               load,
    input  logic [DAY_W-1:0]   loadDay,
    input  logic [MONTH_W-1:0] loadMonth,
    input  logic [YEAR_W-1:0]  loadYear,
    output logic [DAY_W-1:0]   dayOfMonth,
    output logic [MONTH_W-1:0] month,
    output logic [YEAR_W-1:0]  year,
    output logic               isLeap,
    output logic               newYear,
    output logic               yearWrap,
    output logic               loadErr
);

    logic [DAY_W-1:0]   day_q, day_d;
    logic [MONTH_W-1:0] month_q, month_d;
    logic [YEAR_W-1:0]  year_q, year_d;
    logic               new_year_q, new_year_d;
    logic               year_wrap_q, year_wrap_d;
    logic               load_err_q, load_err_d;

    logic [DAY_W-1:0]   cur_len;
    logic               cur_leap;
    logic [DAY_W-1:0]   ld_len;
    logic               ld_leap;
    logic               load_ok;

    month_length_lut #(
        .YEAR_W (YEAR_W)
    ) u_cur_lut (
        .month_i  (month_q),
        .year_i   (year_q),
        .length_o (cur_len),
        .leap_o   (cur_leap)
    );

    // Validation uses the leap status of the year being loaded, not the current one.
    month_length_lut #(
        .YEAR_W (YEAR_W)
    ) u_load_lut (
        .month_i  (loadMonth),
        .year_i   (loadYear),
        .length_o (ld_len),
        .leap_o   (ld_leap)
    );

    // ld_len is 0 for an illegal month, so the day bound also rejects months 0 and 13..15.
    assign load_ok = (loadDay != '0) && (loadDay <= ld_len);

    always_comb begin
        day_d       = day_q;
        month_d     = month_q;
        year_d      = year_q;
        new_year_d  = 1'b0;
        year_wrap_d = 1'b0;
        load_err_d  = 1'b0;

        if (load) begin
            if (load_ok) begin
                day_d   = loadDay;
                month_d = loadMonth;
                year_d  = loadYear;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (advance) begin
            if (day_q < cur_len) begin
                day_d = day_q + DAY_W'(1);
            end else begin
                day_d = DAY_W'(1);
                if (month_q < MONTH_W'(12)) begin
                    month_d = month_q + MONTH_W'(1);
                end else begin
                    month_d     = MONTH_W'(1);
                    year_d      = year_q + YEAR_W'(1);
                    new_year_d  = 1'b1;
                    year_wrap_d = (year_q == {YEAR_W{1'b1}});
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            day_q       <= DAY_W'(RESET_DAY);
            month_q     <= MONTH_W'(RESET_MONTH);
            year_q      <= YEAR_W'(RESET_YEAR);
            new_year_q  <= 1'b0;
            year_wrap_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            day_q       <= day_d;
            month_q     <= month_d;
            year_q      <= year_d;
            new_year_q  <= new_year_d;
            year_wrap_q <= year_wrap_d;
            load_err_q  <= load_err_d;
        end
    end

    assign dayOfMonth = day_q;
    assign month      = month_q;
    assign year       = year_q;
    assign isLeap     = cur_leap;
    assign newYear    = new_year_q;
    assign yearWrap   = year_wrap_q;
    assign loadErr    = load_err_q;

    // ld_leap only feeds the length lookup inside the LUT instance.
    logic unused_ld_leap;
    assign unused_ld_leap = ld_leap;

endmodule

// File: tb/tb_date_counter.sv
module tb_date_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        advance = 1'b0;
    logic        load = 1'b0;
    logic [5:0]  loadDay = '0;
    logic [3:0]  loadMonth = '0;
    logic [11:0] loadYear = '0;
    logic [5:0]  dayOfMonth;
    logic [3:0]  month;
    logic [11:0] year;
    logic        isLeap, newYear, yearWrap, loadErr;

    int n_checks = 0;
    int n_pass   = 0;
    logic inv_en = 1'b0;

    always #5 clk = ~clk;

    date_counter #(
        .YEAR_W      (12),
        .RESET_YEAR  (2000),
        .RESET_MONTH (1),
        .RESET_DAY   (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .advance    (advance),
        .load       (load),
        .loadDay    (loadDay),
        .loadMonth  (loadMonth),
        .loadYear   (loadYear),
        .dayOfMonth (dayOfMonth),
        .month      (month),
        .year       (year),
        .isLeap     (isLeap),
        .newYear    (newYear),
        .yearWrap   (yearWrap),
        .loadErr    (loadErr)
    );

    function automatic bit leap_ref(input int y);
        if (y % 400 == 0) return 1'b1;
        if (y % 100 == 0) return 1'b0;
        return (y % 4 == 0);
    endfunction

    function automatic int days_in(input int m, input int y);
        case (m)
            4, 6, 9, 11: return 30;
            2:           return leap_ref(y) ? 29 : 28;
            default:     return 31;
        endcase
    endfunction

    // Stands in for the downstream day-of-year calculator.
    function automatic int doy_ref(input int d, input int m, input int y);
        int acc;
        acc = d;
        for (int k = 1; k < m; k++) acc += days_in(k, y);
        return acc;
    endfunction

    always @(negedge clk) begin
        if (inv_en) begin
            n_checks++;
            if (month < 4'd1 || month > 4'd12 || dayOfMonth < 6'd1 ||
                int'(dayOfMonth) > days_in(int'(month), int'(year)))
                $display("FAIL invariant: got %0d-%0d-%0d, day must be 1..month length",
                         year, month, dayOfMonth);
            else n_pass++;
        end
    end

    task automatic cycle(input logic ld, input logic adv, input int d, input int m, input int y);
        @(negedge clk);
        load      = ld;
        advance   = adv;
        loadDay   = 6'(d);
        loadMonth = 4'(m);
        loadYear  = 12'(y);
        @(posedge clk);
        #1;
        load    = 1'b0;
        advance = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({year, month, dayOfMonth, isLeap, newYear, yearWrap, loadErr} !==
            {12'd2000, 4'd1, 6'd1, 1'b1, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_state: got %0d-%0d-%0d leap=%b ny=%b yw=%b le=%b want 2000-1-1 1000",
                     year, month, dayOfMonth, isLeap, newYear, yearWrap, loadErr);
        else n_pass++;
        inv_en = 1'b1;
        cycle(1'b0, 1'b0, 0, 0, 0);
        n_checks++;
        if ({year, month, dayOfMonth, newYear} !== {12'd2000, 4'd1, 6'd1, 1'b0})
            $display("FAIL idle_hold: got %0d-%0d-%0d ny=%b want 2000-1-1 ny=0",
                     year, month, dayOfMonth, newYear);
        else n_pass++;
    endtask

    task automatic test_year_sweep;
        cycle(1'b1, 1'b0, 1, 1, 2001);
        n_checks++;
        if (doy_ref(int'(dayOfMonth), int'(month), int'(year)) != 1 || year !== 12'd2001 ||
            newYear !== 1'b0 || loadErr !== 1'b0)
            $display("FAIL sweep_start: got %0d-%0d-%0d ny=%b le=%b want 2001-1-1 ny=0 le=0",
                     year, month, dayOfMonth, newYear, loadErr);
        else n_pass++;
        for (int k = 1; k < 365; k++) begin
            cycle(1'b0, 1'b1, 0, 0, 0);
            n_checks++;
            if (doy_ref(int'(dayOfMonth), int'(month), int'(year)) != k + 1 ||
                year !== 12'd2001 || newYear !== 1'b0)
                $display("FAIL sweep_doy: got doy %0d (%0d-%0d-%0d ny=%b) want %0d ny=0",
                         doy_ref(int'(dayOfMonth), int'(month), int'(year)),
                         year, month, dayOfMonth, newYear, k + 1);
            else n_pass++;
        end
        cycle(1'b0, 1'b1, 0, 0, 0);
        n_checks++;
        if ({year, month, dayOfMonth, newYear, yearWrap, isLeap} !==
            {12'd2002, 4'd1, 6'd1, 1'b1, 1'b0, 1'b0})
            $display("FAIL sweep_newyear: got %0d-%0d-%0d ny=%b yw=%b leap=%b want 2002-1-1 1 0 0",
                     year, month, dayOfMonth, newYear, yearWrap, isLeap);
        else n_pass++;
        cycle(1'b0, 1'b0, 0, 0, 0);
        n_checks++;
        if (newYear !== 1'b0)
            $display("FAIL newyear_one_cycle: got ny=%b want 0", newYear);
        else n_pass++;
    endtask

    task automatic test_leap;
        cycle(1'b1, 1'b0, 28, 2, 2024);
        cycle(1'b0, 1'b1, 0, 0, 0);
        n_checks++;
        if ({year, month, dayOfMonth, isLeap} !== {12'd2024, 4'd2, 6'd29, 1'b1})
            $display("FAIL leap_2024_0229: got %0d-%0d-%0d leap=%b want 2024-2-29 1",
                     year, month, dayOfMonth, isLeap);
        else n_pass++;
        cycle(1'b0, 1'b1, 0, 0, 0);
        n_checks++;
        if ({year, month, dayOfMonth} !== {12'd2024, 4'd3, 6'd1})
            $display("FAIL leap_2024_0301: got %0d-%0d-%0d want 2024-3-1", year, month, dayOfMonth);
        else n_pass++;
        cycle(1'b1, 1'b0, 28, 2, 1900);
        cycle(1'b0, 1'b1, 0, 0, 0);
        n_checks++;
        if ({year, month, dayOfMonth, isLeap} !== {12'd1900, 4'd3, 6'd1, 1'b0})
            $display("FAIL leap_1900: got %0d-%0d-%0d leap=%b want 1900-3-1 0",
                     year, month, dayOfMonth, isLeap);
        else n_pass++;
        cycle(1'b1, 1'b0, 28, 2, 2000);
        cycle(1'b0, 1'b1, 0, 0, 0);
        n_checks++;
        if ({year, month, dayOfMonth, isLeap} !== {12'd2000, 4'd2, 6'd29, 1'b1})
            $display("FAIL leap_2000: got %0d-%0d-%0d leap=%b want 2000-2-29 1",
                     year, month, dayOfMonth, isLeap);
        else n_pass++;
    endtask

    task automatic test_load_validation;
        cycle(1'b1, 1'b0, 5, 5, 2020);
        cycle(1'b1, 1'b0, 29, 2, 2023);
        n_checks++;
        if ({year, month, dayOfMonth, loadErr} !== {12'd2020, 4'd5, 6'd5, 1'b1})
            $display("FAIL load_2023_0229: got %0d-%0d-%0d le=%b want 2020-5-5 le=1",
                     year, month, dayOfMonth, loadErr);
        else n_pass++;
        cycle(1'b0, 1'b0, 0, 0, 0);
        n_checks++;
        if (loadErr !== 1'b0)
            $display("FAIL loaderr_one_cycle: got le=%b want 0", loadErr);
        else n_pass++;
        cycle(1'b1, 1'b0, 29, 2, 2024);
        n_checks++;
        if ({year, month, dayOfMonth, loadErr} !== {12'd2024, 4'd2, 6'd29, 1'b0})
            $display("FAIL load_2024_0229: got %0d-%0d-%0d le=%b want 2024-2-29 le=0",
                     year, month, dayOfMonth, loadErr);
        else n_pass++;
        cycle(1'b1, 1'b0, 1, 13, 2024);
        n_checks++;
        if ({year, month, dayOfMonth, loadErr} !== {12'd2024, 4'd2, 6'd29, 1'b1})
            $display("FAIL load_month13: got %0d-%0d-%0d le=%b want 2024-2-29 le=1",
                     year, month, dayOfMonth, loadErr);
        else n_pass++;
        cycle(1'b1, 1'b0, 0, 3, 2024);
        n_checks++;
        if ({year, month, dayOfMonth, loadErr} !== {12'd2024, 4'd2, 6'd29, 1'b1})
            $display("FAIL load_day0: got %0d-%0d-%0d le=%b want 2024-2-29 le=1",
                     year, month, dayOfMonth, loadErr);
        else n_pass++;
        cycle(1'b1, 1'b0, 31, 4, 2024);
        n_checks++;
        if ({year, month, dayOfMonth, loadErr} !== {12'd2024, 4'd2, 6'd29, 1'b1})
            $display("FAIL load_0431: got %0d-%0d-%0d le=%b want 2024-2-29 le=1",
                     year, month, dayOfMonth, loadErr);
        else n_pass++;
        cycle(1'b1, 1'b0, 1, 1, 2030);
        n_checks++;
        if ({year, month, dayOfMonth, loadErr, newYear} !== {12'd2030, 4'd1, 6'd1, 1'b0, 1'b0})
            $display("FAIL load_jan1_no_newyear: got %0d-%0d-%0d le=%b ny=%b want 2030-1-1 0 0",
                     year, month, dayOfMonth, loadErr, newYear);
        else n_pass++;
    endtask

    task automatic test_simultaneous;
        cycle(1'b1, 1'b1, 15, 6, 2010);
        n_checks++;
        if ({year, month, dayOfMonth} !== {12'd2010, 4'd6, 6'd15})
            $display("FAIL load_beats_advance: got %0d-%0d-%0d want 2010-6-15",
                     year, month, dayOfMonth);
        else n_pass++;
        cycle(1'b1, 1'b0, 31, 13, 2010);
        @(negedge clk);
        reset     = 1'b1;
        load      = 1'b1;
        advance   = 1'b1;
        loadDay   = 6'd20;
        loadMonth = 4'd7;
        loadYear  = 12'd2015;
        @(posedge clk);
        #1;
        n_checks++;
        if ({year, month, dayOfMonth, newYear, yearWrap, loadErr} !==
            {12'd2000, 4'd1, 6'd1, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_beats_load: got %0d-%0d-%0d ny=%b yw=%b le=%b want 2000-1-1 000",
                     year, month, dayOfMonth, newYear, yearWrap, loadErr);
        else n_pass++;
        reset   = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
    endtask

    task automatic test_year_wrap;
        cycle(1'b1, 1'b0, 31, 12, 4095);
        n_checks++;
        if ({year, isLeap} !== {12'd4095, 1'b0})
            $display("FAIL wrap_load_4095: got y=%0d leap=%b want 4095 0", year, isLeap);
        else n_pass++;
        cycle(1'b0, 1'b1, 0, 0, 0);
        n_checks++;
        if ({year, month, dayOfMonth, newYear, yearWrap, isLeap} !==
            {12'd0, 4'd1, 6'd1, 1'b1, 1'b1, 1'b1})
            $display("FAIL year_wrap: got %0d-%0d-%0d ny=%b yw=%b leap=%b want 0-1-1 1 1 1",
                     year, month, dayOfMonth, newYear, yearWrap, isLeap);
        else n_pass++;
        cycle(1'b0, 1'b0, 0, 0, 0);
        n_checks++;
        if ({newYear, yearWrap, year} !== {1'b0, 1'b0, 12'd0})
            $display("FAIL wrap_pulses_clear: got ny=%b yw=%b y=%0d want 0 0 0",
                     newYear, yearWrap, year);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_year_sweep();
        test_leap();
        test_load_validation();
        test_simultaneous();
        test_year_wrap();
        @(negedge clk);
        inv_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
